// File: rtl/wshb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wshb_arb_pkg
//  Purpose  : Shared types and bus widths for the SDRAM Wishbone arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package wshb_arb_pkg;

    localparam int ADR_W  = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_VGA  = 2'd1,
        GNT_MIRE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_VGA  = 1'b0,
        OWN_MIRE = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/wshb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wshb_arbiter
//  Purpose  : Shares the SDRAM Wishbone slave between the VGA frame reader
//             and the mire pattern writer. Round-robin with optional VGA
//             priority; the grant is held for a whole bus cycle. Exports the
//             largest VGA request-to-grant wait for debug.
//  Revision : 1.0 - initial release
// ============================================================================
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter bit          VGA_PRIORITY = 1'b1,
    parameter int unsigned STAT_W       = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    // VGA master side
    input  logic              wshb_ifs_vga_cyc,
    input  logic              wshb_ifs_vga_stb,
    input  logic              wshb_ifs_vga_we,
    input  logic [ADR_W-1:0]  wshb_ifs_vga_adr,
    input  logic [DATA_W-1:0] wshb_ifs_vga_dat_ms,
    input  logic [SEL_W-1:0]  wshb_ifs_vga_sel,
    input  logic [2:0]        wshb_ifs_vga_cti,
    input  logic [1:0]        wshb_ifs_vga_bte,
    output logic [DATA_W-1:0] wshb_ifs_vga_dat_sm,
    output logic              wshb_ifs_vga_ack,
    output logic              wshb_ifs_vga_err,
    output logic              wshb_ifs_vga_rty,
    // mire master side
    input  logic              wshb_ifs_mire_cyc,
    input  logic              wshb_ifs_mire_stb,
    input  logic              wshb_ifs_mire_we,
    input  logic [ADR_W-1:0]  wshb_ifs_mire_adr,
    input  logic [DATA_W-1:0] wshb_ifs_mire_dat_ms,
    input  logic [SEL_W-1:0]  wshb_ifs_mire_sel,
    input  logic [2:0]        wshb_ifs_mire_cti,
    input  logic [1:0]        wshb_ifs_mire_bte,
    output logic [DATA_W-1:0] wshb_ifs_mire_dat_sm,
    output logic              wshb_ifs_mire_ack,
    output logic              wshb_ifs_mire_err,
    output logic              wshb_ifs_mire_rty,
    // SDRAM slave side
    output logic              wshb_ifm_sdram_cyc,
    output logic              wshb_ifm_sdram_stb,
    output logic              wshb_ifm_sdram_we,
    output logic [ADR_W-1:0]  wshb_ifm_sdram_adr,
    output logic [DATA_W-1:0] wshb_ifm_sdram_dat_ms,
    output logic [SEL_W-1:0]  wshb_ifm_sdram_sel,
    output logic [2:0]        wshb_ifm_sdram_cti,
    output logic [1:0]        wshb_ifm_sdram_bte,
    input  logic [DATA_W-1:0] wshb_ifm_sdram_dat_sm,
    input  logic              wshb_ifm_sdram_ack,
    input  logic              wshb_ifm_sdram_err,
    input  logic              wshb_ifm_sdram_rty,
    // statistics / status
    input  logic              clr_stats,
    output logic [STAT_W-1:0] vga_wait_max,
    output logic              grant_vga
);

    localparam logic [STAT_W-1:0] c_stat_max = '1;
    localparam logic [STAT_W-1:0] c_stat_one = {{(STAT_W-1){1'b0}}, 1'b1};

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    owner_t            r_last_owner;
    logic              r_grant_vga;
    logic [STAT_W-1:0] r_wait_cnt;
    logic [STAT_W-1:0] r_vga_wait_max;
    logic [STAT_W-1:0] w_wait_inc;
    logic              w_vga_waiting;
    logic              w_enter_vga;

    // Next owner: a grant is only released when its owner drops cyc, and the
    // other master is handed the bus directly with no idle turnaround.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (wshb_ifs_vga_cyc && wshb_ifs_mire_cyc)
                    w_next_state = (VGA_PRIORITY || (r_last_owner == OWN_MIRE)) ? GNT_VGA : GNT_MIRE;
                else if (wshb_ifs_vga_cyc)
                    w_next_state = GNT_VGA;
                else if (wshb_ifs_mire_cyc)
                    w_next_state = GNT_MIRE;
            end
            GNT_VGA: begin
                if (!wshb_ifs_vga_cyc)
                    w_next_state = wshb_ifs_mire_cyc ? GNT_MIRE : IDLE;
            end
            GNT_MIRE: begin
                if (!wshb_ifs_mire_cyc)
                    w_next_state = wshb_ifs_vga_cyc ? GNT_VGA : IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Arbitration FSM: state, round-robin memory and the registered grant flag.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state      <= IDLE;
            r_last_owner <= OWN_MIRE;
            r_grant_vga  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_grant_vga <= (w_next_state == GNT_VGA);
            if (r_state == GNT_VGA && !wshb_ifs_vga_cyc)
                r_last_owner <= OWN_VGA;
            else if (r_state == GNT_MIRE && !wshb_ifs_mire_cyc)
                r_last_owner <= OWN_MIRE;
        end
    end

    // Forward the owner's request to SDRAM and route the response back to it.
    always_comb begin
        wshb_ifm_sdram_cyc    = 1'b0;
        wshb_ifm_sdram_stb    = 1'b0;
        wshb_ifm_sdram_we     = 1'b0;
        wshb_ifm_sdram_adr    = '0;
        wshb_ifm_sdram_dat_ms = '0;
        wshb_ifm_sdram_sel    = '0;
        wshb_ifm_sdram_cti    = '0;
        wshb_ifm_sdram_bte    = '0;
        wshb_ifs_vga_ack      = 1'b0;
        wshb_ifs_vga_err      = 1'b0;
        wshb_ifs_vga_rty      = 1'b0;
        wshb_ifs_mire_ack     = 1'b0;
        wshb_ifs_mire_err     = 1'b0;
        wshb_ifs_mire_rty     = 1'b0;
        case (r_state)
            GNT_VGA: begin
                wshb_ifm_sdram_cyc    = wshb_ifs_vga_cyc;
                wshb_ifm_sdram_stb    = wshb_ifs_vga_stb;
                wshb_ifm_sdram_we     = wshb_ifs_vga_we;
                wshb_ifm_sdram_adr    = wshb_ifs_vga_adr;
                wshb_ifm_sdram_dat_ms = wshb_ifs_vga_dat_ms;
                wshb_ifm_sdram_sel    = wshb_ifs_vga_sel;
                wshb_ifm_sdram_cti    = wshb_ifs_vga_cti;
                wshb_ifm_sdram_bte    = wshb_ifs_vga_bte;
                wshb_ifs_vga_ack      = wshb_ifm_sdram_ack;
                wshb_ifs_vga_err      = wshb_ifm_sdram_err;
                wshb_ifs_vga_rty      = wshb_ifm_sdram_rty;
            end
            GNT_MIRE: begin
                wshb_ifm_sdram_cyc    = wshb_ifs_mire_cyc;
                wshb_ifm_sdram_stb    = wshb_ifs_mire_stb;
                wshb_ifm_sdram_we     = wshb_ifs_mire_we;
                wshb_ifm_sdram_adr    = wshb_ifs_mire_adr;
                wshb_ifm_sdram_dat_ms = wshb_ifs_mire_dat_ms;
                wshb_ifm_sdram_sel    = wshb_ifs_mire_sel;
                wshb_ifm_sdram_cti    = wshb_ifs_mire_cti;
                wshb_ifm_sdram_bte    = wshb_ifs_mire_bte;
                wshb_ifs_mire_ack     = wshb_ifm_sdram_ack;
                wshb_ifs_mire_err     = wshb_ifm_sdram_err;
                wshb_ifs_mire_rty     = wshb_ifm_sdram_rty;
            end
            default: ;
        endcase
    end

    assign wshb_ifs_vga_dat_sm  = wshb_ifm_sdram_dat_sm;
    assign wshb_ifs_mire_dat_sm = wshb_ifm_sdram_dat_sm;

    // The entry cycle itself is a waiting cycle, so the recorded wait is the
    // saturated count including it.
    assign w_vga_waiting = wshb_ifs_vga_cyc && (r_state != GNT_VGA);
    assign w_enter_vga   = (w_next_state == GNT_VGA) && (r_state != GNT_VGA);
    assign w_wait_inc    = (r_wait_cnt == c_stat_max) ? c_stat_max : (r_wait_cnt + c_stat_one);

    // Saturating count of cycles VGA spends requesting without the bus.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n)
            r_wait_cnt <= '0;
        else if (w_enter_vga)
            r_wait_cnt <= '0;
        else if (w_vga_waiting)
            r_wait_cnt <= w_wait_inc;
    end

    // Peak VGA wait, captured on grant; a clear request overrides a capture.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n)
            r_vga_wait_max <= '0;
        else if (clr_stats)
            r_vga_wait_max <= '0;
        else if (w_enter_vga && (w_wait_inc > r_vga_wait_max))
            r_vga_wait_max <= w_wait_inc;
    end

    assign vga_wait_max = r_vga_wait_max;
    assign grant_vga    = r_grant_vga;

endmodule
`default_nettype wire

// File: tb/tb_wshb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wshb_arbiter
//  Purpose  : Self-checking bench for wshb_arbiter. Two instances share the
//             stimulus: round-robin with 16-bit stats, and VGA priority with
//             4-bit stats. A bus-ownership model predicts every output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wshb_arbiter;

    localparam int O_NONE = 0;
    localparam int O_VGA  = 1;
    localparam int O_MIRE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clr;
    logic        v_cyc, v_stb, v_we, m_cyc, m_stb, m_we;
    logic [31:0] v_adr, v_dat, m_adr, m_dat, s_dat;
    logic [3:0]  v_sel, m_sel;
    logic [2:0]  v_cti, m_cti;
    logic [1:0]  v_bte, m_bte;
    logic        s_ack, s_err, s_rty;

    logic [31:0] o_vdat [2];
    logic [31:0] o_mdat [2];
    logic        o_vack [2];
    logic        o_verr [2];
    logic        o_vrty [2];
    logic        o_mack [2];
    logic        o_merr [2];
    logic        o_mrty [2];
    logic        o_cyc  [2];
    logic        o_stb  [2];
    logic        o_we   [2];
    logic [31:0] o_adr  [2];
    logic [31:0] o_dat  [2];
    logic [3:0]  o_sel  [2];
    logic [2:0]  o_cti  [2];
    logic [1:0]  o_bte  [2];
    logic        o_gv   [2];
    logic [15:0] wmax0;
    logic [3:0]  wmax1;

    wshb_arbiter #(.VGA_PRIORITY(1'b0), .STAT_W(16)) dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .wshb_ifs_vga_cyc(v_cyc), .wshb_ifs_vga_stb(v_stb), .wshb_ifs_vga_we(v_we),
        .wshb_ifs_vga_adr(v_adr), .wshb_ifs_vga_dat_ms(v_dat), .wshb_ifs_vga_sel(v_sel),
        .wshb_ifs_vga_cti(v_cti), .wshb_ifs_vga_bte(v_bte), .wshb_ifs_vga_dat_sm(o_vdat[0]),
        .wshb_ifs_vga_ack(o_vack[0]), .wshb_ifs_vga_err(o_verr[0]), .wshb_ifs_vga_rty(o_vrty[0]),
        .wshb_ifs_mire_cyc(m_cyc), .wshb_ifs_mire_stb(m_stb), .wshb_ifs_mire_we(m_we),
        .wshb_ifs_mire_adr(m_adr), .wshb_ifs_mire_dat_ms(m_dat), .wshb_ifs_mire_sel(m_sel),
        .wshb_ifs_mire_cti(m_cti), .wshb_ifs_mire_bte(m_bte), .wshb_ifs_mire_dat_sm(o_mdat[0]),
        .wshb_ifs_mire_ack(o_mack[0]), .wshb_ifs_mire_err(o_merr[0]), .wshb_ifs_mire_rty(o_mrty[0]),
        .wshb_ifm_sdram_cyc(o_cyc[0]), .wshb_ifm_sdram_stb(o_stb[0]), .wshb_ifm_sdram_we(o_we[0]),
        .wshb_ifm_sdram_adr(o_adr[0]), .wshb_ifm_sdram_dat_ms(o_dat[0]), .wshb_ifm_sdram_sel(o_sel[0]),
        .wshb_ifm_sdram_cti(o_cti[0]), .wshb_ifm_sdram_bte(o_bte[0]), .wshb_ifm_sdram_dat_sm(s_dat),
        .wshb_ifm_sdram_ack(s_ack), .wshb_ifm_sdram_err(s_err), .wshb_ifm_sdram_rty(s_rty),
        .clr_stats(clr), .vga_wait_max(wmax0), .grant_vga(o_gv[0])
    );

    wshb_arbiter #(.VGA_PRIORITY(1'b1), .STAT_W(4)) dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .wshb_ifs_vga_cyc(v_cyc), .wshb_ifs_vga_stb(v_stb), .wshb_ifs_vga_we(v_we),
        .wshb_ifs_vga_adr(v_adr), .wshb_ifs_vga_dat_ms(v_dat), .wshb_ifs_vga_sel(v_sel),
        .wshb_ifs_vga_cti(v_cti), .wshb_ifs_vga_bte(v_bte), .wshb_ifs_vga_dat_sm(o_vdat[1]),
        .wshb_ifs_vga_ack(o_vack[1]), .wshb_ifs_vga_err(o_verr[1]), .wshb_ifs_vga_rty(o_vrty[1]),
        .wshb_ifs_mire_cyc(m_cyc), .wshb_ifs_mire_stb(m_stb), .wshb_ifs_mire_we(m_we),
        .wshb_ifs_mire_adr(m_adr), .wshb_ifs_mire_dat_ms(m_dat), .wshb_ifs_mire_sel(m_sel),
        .wshb_ifs_mire_cti(m_cti), .wshb_ifs_mire_bte(m_bte), .wshb_ifs_mire_dat_sm(o_mdat[1]),
        .wshb_ifs_mire_ack(o_mack[1]), .wshb_ifs_mire_err(o_merr[1]), .wshb_ifs_mire_rty(o_mrty[1]),
        .wshb_ifm_sdram_cyc(o_cyc[1]), .wshb_ifm_sdram_stb(o_stb[1]), .wshb_ifm_sdram_we(o_we[1]),
        .wshb_ifm_sdram_adr(o_adr[1]), .wshb_ifm_sdram_dat_ms(o_dat[1]), .wshb_ifm_sdram_sel(o_sel[1]),
        .wshb_ifm_sdram_cti(o_cti[1]), .wshb_ifm_sdram_bte(o_bte[1]), .wshb_ifm_sdram_dat_sm(s_dat),
        .wshb_ifm_sdram_ack(s_ack), .wshb_ifm_sdram_err(s_err), .wshb_ifm_sdram_rty(s_rty),
        .clr_stats(clr), .vga_wait_max(wmax1), .grant_vga(o_gv[1])
    );

    // Reference model: who owns the bus, who was served last, wait statistics.
    int m_owner [2];
    int m_last  [2];
    int m_cnt   [2];
    int m_max   [2];
    int prio    [2] = '{0, 1};
    int satv    [2] = '{65535, 15};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        int nxt, other, w, newmax;
        bit owner_wants, other_wants, waiting;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_owner[k] = O_NONE; m_last[k] = O_MIRE; m_cnt[k] = 0; m_max[k] = 0;
            end else begin
                nxt = m_owner[k];
                if (m_owner[k] == O_NONE) begin
                    if (v_cyc && m_cyc)
                        nxt = (prio[k] != 0 || m_last[k] == O_MIRE) ? O_VGA : O_MIRE;
                    else if (v_cyc)
                        nxt = O_VGA;
                    else if (m_cyc)
                        nxt = O_MIRE;
                end else begin
                    owner_wants = (m_owner[k] == O_VGA) ? v_cyc : m_cyc;
                    other       = (m_owner[k] == O_VGA) ? O_MIRE : O_VGA;
                    other_wants = (other == O_VGA) ? v_cyc : m_cyc;
                    if (!owner_wants) begin
                        m_last[k] = m_owner[k];
                        nxt = other_wants ? other : O_NONE;
                    end
                end
                waiting = v_cyc && (m_owner[k] != O_VGA);
                newmax  = m_max[k];
                if (waiting) begin
                    w = (m_cnt[k] + 1 > satv[k]) ? satv[k] : m_cnt[k] + 1;
                    if (nxt == O_VGA) begin
                        if (w > newmax) newmax = w;
                        m_cnt[k] = 0;
                    end else begin
                        m_cnt[k] = w;
                    end
                end
                m_max[k]   = clr ? 0 : newmax;
                m_owner[k] = nxt;
            end
        end
    endtask

    task automatic check_all();
        logic [75:0] vb, mb, exp_sd, act_sd;
        logic [5:0]  exp_r, act_r;
        vb = {v_cyc, v_stb, v_we, v_adr, v_dat, v_sel, v_cti, v_bte};
        mb = {m_cyc, m_stb, m_we, m_adr, m_dat, m_sel, m_cti, m_bte};
        for (int k = 0; k < 2; k++) begin
            exp_sd = (m_owner[k] == O_VGA) ? vb : (m_owner[k] == O_MIRE) ? mb : '0;
            act_sd = {o_cyc[k], o_stb[k], o_we[k], o_adr[k], o_dat[k], o_sel[k], o_cti[k], o_bte[k]};
            exp_r  = (m_owner[k] == O_VGA)  ? {s_ack, s_err, s_rty, 3'b000} :
                     (m_owner[k] == O_MIRE) ? {3'b000, s_ack, s_err, s_rty} : 6'b0;
            act_r  = {o_vack[k], o_verr[k], o_vrty[k], o_mack[k], o_merr[k], o_mrty[k]};
            chk($sformatf("sdram_fwd%0d", k), 128'(act_sd), 128'(exp_sd));
            chk($sformatf("resp_route%0d", k), 128'(act_r), 128'(exp_r));
            chk($sformatf("dat_sm%0d", k), 128'({o_vdat[k], o_mdat[k]}), 128'({s_dat, s_dat}));
            chk($sformatf("grant_vga%0d", k), 128'(o_gv[k]), 128'(m_owner[k] == O_VGA));
            chk($sformatf("wait_max%0d", k), (k == 0) ? 128'(wmax0) : 128'(wmax1), 128'(m_max[k]));
        end
    endtask

    // One clock: fresh payload, advance the model, sample 1 ns after the edge.
    task automatic tick();
        v_stb = v_cyc & ($urandom_range(0, 3) != 0);
        m_stb = m_cyc & ($urandom_range(0, 3) != 0);
        v_we  = 1'($urandom);  m_we  = 1'($urandom);
        v_adr = $urandom;      m_adr = $urandom;
        v_dat = $urandom;      m_dat = $urandom;
        v_sel = 4'($urandom);  m_sel = 4'($urandom);
        v_cti = 3'($urandom);  m_cti = 3'($urandom);
        v_bte = 2'($urandom);  m_bte = 2'($urandom);
        s_dat = $urandom;
        s_ack = 1'($urandom);  s_err = 1'($urandom);  s_rty = 1'($urandom);
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    typedef struct {
        bit rst_n;
        bit v;
        bit m;
        bit gv0;
        bit gv1;
        bit cyc;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int vlen, mlen;
        tbl[0] = '{0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 1, 1, 1, 1};
        tbl[2] = '{1, 0, 1, 0, 0, 1};
        tbl[3] = '{1, 1, 1, 0, 0, 1};
        tbl[4] = '{1, 1, 0, 1, 1, 1};
        tbl[5] = '{1, 0, 0, 0, 0, 0};
        tbl[6] = '{1, 1, 1, 0, 1, 1};
        tbl[7] = '{1, 1, 1, 0, 1, 1};
        tbl[8] = '{1, 1, 0, 1, 1, 1};
        tbl[9] = '{1, 0, 0, 0, 0, 0};

        for (int k = 0; k < 2; k++) begin
            m_owner[k] = O_NONE; m_last[k] = O_MIRE; m_cnt[k] = 0; m_max[k] = 0;
        end
        rst_n = 1'b0; clr = 1'b0; v_cyc = 1'b0; m_cyc = 1'b0;

        // Grant sequencing vectors: round-robin vs VGA priority.
        for (int i = 0; i < 10; i++) begin
            rst_n = tbl[i].rst_n; v_cyc = tbl[i].v; m_cyc = tbl[i].m;
            tick();
            chk($sformatf("tbl%0d_gv0", i), 128'(o_gv[0]), 128'(tbl[i].gv0));
            chk($sformatf("tbl%0d_gv1", i), 128'(o_gv[1]), 128'(tbl[i].gv1));
            chk($sformatf("tbl%0d_cyc", i), 128'({o_cyc[0], o_cyc[1]}), 128'({tbl[i].cyc, tbl[i].cyc}));
        end

        // VGA alone after reset: granted next cycle, address and ack routed to it.
        rst_n = 1'b0; v_cyc = 1'b0; m_cyc = 1'b0; tick();
        rst_n = 1'b1; v_cyc = 1'b1; tick();
        chk("t1_gv", 128'(o_gv[0]), 128'(1));
        chk("t1_adr", 128'(o_adr[0]), 128'(v_adr));
        chk("t1_ack", 128'({o_vack[0], o_mack[0]}), 128'({s_ack, 1'b0}));

        // Mire owns the bus while VGA waits 10 cycles.
        rst_n = 1'b0; v_cyc = 1'b0; m_cyc = 1'b0; tick();
        rst_n = 1'b1; m_cyc = 1'b1; tick();
        v_cyc = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("t3_vack", 128'(o_vack[0]), 128'(0));
        end
        m_cyc = 1'b0; tick();
        chk("t3_gv", 128'(o_gv[0]), 128'(1));
        chk("t3_max0", 128'(wmax0), 128'(10));
        chk("t3_max1", 128'(wmax1), 128'(10));

        // 20-cycle wait: 16-bit stat records it, 4-bit stat saturates; then clear.
        rst_n = 1'b0; v_cyc = 1'b0; m_cyc = 1'b0; tick();
        rst_n = 1'b1; m_cyc = 1'b1; tick();
        v_cyc = 1'b1;
        for (int i = 0; i < 19; i++) tick();
        m_cyc = 1'b0; tick();
        chk("t6_max0", 128'(wmax0), 128'(20));
        chk("t6_max1", 128'(wmax1), 128'(15));
        clr = 1'b1; tick(); clr = 1'b0;
        chk("t6_clr", 128'({wmax0, wmax1}), 128'(0));

        // Clear on the same edge as a capture: the clear must win.
        v_cyc = 1'b0; tick();
        m_cyc = 1'b1; tick();
        v_cyc = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        m_cyc = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_wins_gv", 128'(o_gv[0]), 128'(1));
        chk("clr_wins_max", 128'({wmax0, wmax1}), 128'(0));

        // Reset in the middle of a VGA burst.
        tick();
        rst_n = 1'b0; tick();
        chk("t5_cyc", 128'({o_cyc[0], o_cyc[1]}), 128'(0));
        chk("t5_ack", 128'({o_vack[0], o_vack[1]}), 128'(0));
        chk("t5_gv", 128'({o_gv[0], o_gv[1]}), 128'(0));
        rst_n = 1'b1;

        // Randomized bursts with occasional clears and resets.
        vlen = 0; mlen = 0;
        for (int i = 0; i < 800; i++) begin
            if (vlen > 0) vlen--; else if ($urandom_range(0, 2) == 0) vlen = $urandom_range(1, 12);
            if (mlen > 0) mlen--; else if ($urandom_range(0, 2) == 0) mlen = $urandom_range(1, 12);
            v_cyc = (vlen > 0);
            m_cyc = (mlen > 0);
            rst_n = ($urandom_range(0, 149) != 0);
            clr   = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
